// File: rtl/auth_msg_rx_handler_pkg.sv
// ----------------------------------------------------------------------------
// auth_msg_rx_handler_pkg
//   Shared constants for the authentication message receive path: default
//   message width, protocol version, message-type codes, error codes, source
//   encodings and the receive FSM state constants. Also holds the header
//   check used by the handler.
//   No ports (package).
// ----------------------------------------------------------------------------
package auth_msg_rx_handler_pkg;

    typedef logic [7:0] hdr_byte_t;
    typedef logic [1:0] err_code_t;

    localparam int MSG_LEN_DEFAULT = 512;

    localparam hdr_byte_t AUTH_PROTO_VER = 8'h01;

    localparam hdr_byte_t MT_GET_DIGESTS     = 8'h81;
    localparam hdr_byte_t MT_GET_CERTIFICATE = 8'h82;
    localparam hdr_byte_t MT_CHALLENGE       = 8'h83;
    localparam hdr_byte_t MT_DIGESTS         = 8'h01;
    localparam hdr_byte_t MT_CERTIFICATE     = 8'h02;
    localparam hdr_byte_t MT_CHALLENGE_AUTH  = 8'h03;
    localparam hdr_byte_t MT_ERROR           = 8'h7F;

    localparam err_code_t ERR_NONE        = 2'b00;
    localparam err_code_t ERR_BAD_VERSION = 2'b01;
    localparam err_code_t ERR_BAD_TYPE    = 2'b10;

    localparam logic SRC_PD    = 1'b0;
    localparam logic SRC_DEBUG = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Version mismatch outranks an unknown type.
    function automatic err_code_t header_error(input hdr_byte_t version,
                                               input hdr_byte_t msg_type);
        if (version != AUTH_PROTO_VER) begin
            return ERR_BAD_VERSION;
        end
        case (msg_type)
            MT_GET_DIGESTS, MT_GET_CERTIFICATE, MT_CHALLENGE,
            MT_DIGESTS, MT_CERTIFICATE, MT_CHALLENGE_AUTH, MT_ERROR: return ERR_NONE;
            default: return ERR_BAD_TYPE;
        endcase
    endfunction

endpackage

// File: rtl/auth_msg_rx_handler_fifo.sv
// ----------------------------------------------------------------------------
// auth_msg_fifo
//   Output queue of the receive handler. Entries are {src, message}.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   A pop on an empty queue is ignored; a push is accepted when not full or
//   when a pop happens on the same edge.
// Ports
//   clk, reset     clock, synchronous active-high reset (pointers only)
//   push, wr_data  write request and entry
//   pop            read request (advance head)
//   rd_data        head entry (combinational)
//   full, empty    occupancy flags
// ----------------------------------------------------------------------------
module auth_msg_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/auth_msg_rx_handler.sv
// ----------------------------------------------------------------------------
// auth_msg_rx_handler
//   Receives authentication messages from the PD and DEBUG drivers, arbitrates
//   between them (round-robin on contention), acks the winner for one cycle,
//   checks the 32-bit header {version, type, param1, param2} and queues good
//   messages for the downstream authentication FSM. Rejected messages are
//   dropped and reported on err_valid/err_code.
//   Optional feature: define AUTH_RX_ERR_COUNT_EN to add the saturating
//   err_count output.
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   auth_msg_in                      message from the driver side
//   PD_msg_ready, DEBUG_msg_ready    level requests from each source
//   PD_ready, DEBUG_ready            1-cycle capture acks
//   msg_valid, msg_take              queue head valid / pop
//   msg_data, msg_src                head message and its source (0=PD)
//   msg_type, msg_param1, msg_param2 decoded header bytes 1..3 of the head
//   err_valid, err_code              reject pulse and held reason code
//   err_count                        saturating reject count (optional)
// ----------------------------------------------------------------------------
module auth_msg_rx_handler
    import auth_msg_rx_handler_pkg::*;
#(
    parameter int MSG_LEN    = MSG_LEN_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MSG_LEN-1:0] auth_msg_in,
    input  logic               PD_msg_ready,
    input  logic               DEBUG_msg_ready,
    output logic               PD_ready,
    output logic               DEBUG_ready,
    output logic               msg_valid,
    input  logic               msg_take,
    output logic [MSG_LEN-1:0] msg_data,
    output logic               msg_src,
    output logic [7:0]         msg_type,
    output logic [7:0]         msg_param1,
    output logic [7:0]         msg_param2,
    output logic               err_valid,
    output logic [1:0]         err_code
`ifdef AUTH_RX_ERR_COUNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    logic [1:0]         state;
    logic               last_grant;
    logic               grant_pd;
    logic               grant_dbg;
    logic               grant_any;
    logic [MSG_LEN-1:0] stage_msg_p0;
    logic               stage_src_p0;
    logic               vld_p0;
    err_code_t          hdr_err;
    logic               fifo_full;
    logic               fifo_empty;
    logic               space;
    logic               push;
    logic               pop;
    logic [MSG_LEN:0]   head_entry;

    // Arbiter: a lone requester wins; on contention the source that did not
    // win last time gets the grant.
    always_comb begin
        grant_pd  = 1'b0;
        grant_dbg = 1'b0;
        if (PD_msg_ready && DEBUG_msg_ready) begin
            if (last_grant == SRC_DEBUG) begin
                grant_pd = 1'b1;
            end else begin
                grant_dbg = 1'b1;
            end
        end else if (PD_msg_ready) begin
            grant_pd = 1'b1;
        end else if (DEBUG_msg_ready) begin
            grant_dbg = 1'b1;
        end
    end

    assign grant_any = (state == ST_IDLE) && (grant_pd || grant_dbg);

    // ---- stage p0: captured message awaiting header check ----
    always_ff @(posedge clk) begin
        if (grant_any) begin
            stage_msg_p0 <= auth_msg_in;
        end
    end

    assign vld_p0  = (state == ST_CHECK);
    assign hdr_err = header_error(stage_msg_p0[MSG_LEN-1 -: 8],
                                  stage_msg_p0[MSG_LEN-9 -: 8]);

    // A pop on the same edge frees a slot even when the queue is full.
    assign pop   = msg_valid && msg_take;
    assign space = !fifo_full || pop;
    assign push  = space && ((vld_p0 && hdr_err == ERR_NONE) || state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= SRC_DEBUG;
            stage_src_p0 <= SRC_PD;
            PD_ready     <= 1'b0;
            DEBUG_ready  <= 1'b0;
            err_valid    <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            err_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        stage_src_p0 <= grant_dbg;
                        last_grant   <= grant_dbg;
                        PD_ready     <= grant_pd;
                        DEBUG_ready  <= grant_dbg;
                        state        <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    PD_ready    <= 1'b0;
                    DEBUG_ready <= 1'b0;
                    if (hdr_err != ERR_NONE) begin
                        err_valid <= 1'b1;
                        err_code  <= hdr_err;
                        state     <= ST_IDLE;
                    end else if (space) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (space) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AUTH_RX_ERR_COUNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'h00;
        end else if (err_valid) begin
            err_count <= sat_inc8(err_count);
        end
    end
`endif

    // ---- stage p1: output queue ----
    auth_msg_fifo #(
        .WIDTH (MSG_LEN + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({stage_src_p0, stage_msg_p0}),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields are forced to zero while the queue is empty so stale
    // storage never shows on the outputs.
    assign msg_valid  = !fifo_empty;
    assign msg_data   = msg_valid ? head_entry[MSG_LEN-1:0] : '0;
    assign msg_src    = msg_valid && head_entry[MSG_LEN];
    assign msg_type   = msg_data[MSG_LEN-9 -: 8];
    assign msg_param1 = msg_data[MSG_LEN-17 -: 8];
    assign msg_param2 = msg_data[MSG_LEN-25 -: 8];

endmodule

// File: tb/tb_auth_msg_rx_handler.sv
// ----------------------------------------------------------------------------
// tb_auth_msg_rx_handler
//   Self-checking bench for auth_msg_rx_handler: header table, directed
//   multi-cycle sequences (arbitration, back-pressure, reset) and a randomized
//   run against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_auth_msg_rx_handler;

    localparam int MSG_LEN    = 512;
    localparam int FIFO_DEPTH = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [MSG_LEN-1:0] auth_msg_in;
    logic               PD_msg_ready;
    logic               DEBUG_msg_ready;
    logic               PD_ready;
    logic               DEBUG_ready;
    logic               msg_valid;
    logic               msg_take;
    logic [MSG_LEN-1:0] msg_data;
    logic               msg_src;
    logic [7:0]         msg_type;
    logic [7:0]         msg_param1;
    logic [7:0]         msg_param2;
    logic               err_valid;
    logic [1:0]         err_code;
`ifdef AUTH_RX_ERR_COUNT_EN
    logic [7:0]         err_count;
`endif

    auth_msg_rx_handler #(
        .MSG_LEN    (MSG_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .auth_msg_in     (auth_msg_in),
        .PD_msg_ready    (PD_msg_ready),
        .DEBUG_msg_ready (DEBUG_msg_ready),
        .PD_ready        (PD_ready),
        .DEBUG_ready     (DEBUG_ready),
        .msg_valid       (msg_valid),
        .msg_take        (msg_take),
        .msg_data        (msg_data),
        .msg_src         (msg_src),
        .msg_type        (msg_type),
        .msg_param1      (msg_param1),
        .msg_param2      (msg_param2),
        .err_valid       (err_valid),
        .err_code        (err_code)
`ifdef AUTH_RX_ERR_COUNT_EN
        ,
        .err_count       (err_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       src;
        logic [7:0] ver;
        logic [7:0] typ;
        logic [7:0] p1;
        logic [7:0] p2;
        logic       exp_err;
        logic [1:0] exp_code;
    } vec_t;

    typedef struct packed {
        logic               src;
        logic [MSG_LEN-1:0] data;
    } ent_t;

    vec_t       tab [12];
    ent_t       exp_q [$];
    logic [7:0] good_types [7];
    int         mdl_errs;

    task automatic chk(input string name, input logic [MSG_LEN-1:0] act,
                       input logic [MSG_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MSG_LEN-1:0] mk_msg(input logic [7:0] v, input logic [7:0] t,
                                                  input logic [7:0] p1, input logic [7:0] p2);
        logic [MSG_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < MSG_LEN / 32; i++) r[i*32 +: 32] = $urandom;
        r[MSG_LEN-1 -: 32] = {v, t, p1, p2};
        return r;
    endfunction

    // Reference header rule: wrong version first, then unknown type.
    function automatic logic [1:0] ref_err(input logic [7:0] v, input logic [7:0] t);
        if (v != 8'h01) return 2'b01;
        if (t inside {8'h81, 8'h82, 8'h83, 8'h01, 8'h02, 8'h03, 8'h7F}) return 2'b00;
        return 2'b10;
    endfunction

    function automatic logic [MSG_LEN-1:0] rand_msg();
        logic [7:0] v;
        logic [7:0] t;
        v = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h01;
        t = ($urandom_range(0, 5) == 0) ? 8'($urandom) : good_types[$urandom_range(0, 6)];
        return mk_msg(v, t, 8'($urandom), 8'($urandom));
    endfunction

    // One uncontended request: ack checked, request dropped, CHECK edge passed.
    task automatic send_msg(input logic src, input logic [MSG_LEN-1:0] m, input string nm);
        auth_msg_in     = m;
        PD_msg_ready    = (src == 1'b0);
        DEBUG_msg_ready = (src == 1'b1);
        tick();
        chk({nm, "_ack"}, src ? DEBUG_ready : PD_ready, 1'b1);
        chk({nm, "_other_ack"}, src ? PD_ready : DEBUG_ready, 1'b0);
        PD_msg_ready    = 1'b0;
        DEBUG_msg_ready = 1'b0;
        tick();
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_pd_ready"}, PD_ready, 1'b0);
        chk({nm, "_dbg_ready"}, DEBUG_ready, 1'b0);
        chk({nm, "_msg_valid"}, msg_valid, 1'b0);
        chk({nm, "_msg_data"}, msg_data, '0);
        chk({nm, "_msg_src"}, msg_src, 1'b0);
        chk({nm, "_msg_type"}, msg_type, 8'h00);
        chk({nm, "_err_valid"}, err_valid, 1'b0);
        chk({nm, "_err_code"}, err_code, 2'b00);
`ifdef AUTH_RX_ERR_COUNT_EN
        chk({nm, "_err_count"}, err_count, 8'h00);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MSG_LEN-1:0] m, m1, m2, m3, m4;
        logic [1:0]         last_code;
        logic               ack_q [$];
        logic               pop_q [$];

        good_types = '{8'h81, 8'h82, 8'h83, 8'h01, 8'h02, 8'h03, 8'h7F};
        tab[0]  = '{1'b0, 8'h01, 8'h81, 8'h03, 8'h11, 1'b0, 2'b00};
        tab[1]  = '{1'b1, 8'h01, 8'h82, 8'h05, 8'h22, 1'b0, 2'b00};
        tab[2]  = '{1'b0, 8'h02, 8'h82, 8'h00, 8'h00, 1'b1, 2'b01};
        tab[3]  = '{1'b1, 8'h01, 8'h55, 8'h00, 8'h00, 1'b1, 2'b10};
        tab[4]  = '{1'b0, 8'h01, 8'h83, 8'hFF, 8'h00, 1'b0, 2'b00};
        tab[5]  = '{1'b1, 8'h01, 8'h01, 8'h07, 8'h08, 1'b0, 2'b00};
        tab[6]  = '{1'b0, 8'h01, 8'h02, 8'h09, 8'h0A, 1'b0, 2'b00};
        tab[7]  = '{1'b0, 8'h01, 8'h03, 8'h0B, 8'h0C, 1'b0, 2'b00};
        tab[8]  = '{1'b1, 8'h01, 8'h7F, 8'h0D, 8'h0E, 1'b0, 2'b00};
        tab[9]  = '{1'b0, 8'h00, 8'h55, 8'h00, 8'h00, 1'b1, 2'b01};
        tab[10] = '{1'b1, 8'h01, 8'h80, 8'h00, 8'h00, 1'b1, 2'b10};
        tab[11] = '{1'b0, 8'hFF, 8'h7F, 8'h00, 8'h00, 1'b1, 2'b01};

        reset           = 1'b1;
        auth_msg_in     = '0;
        PD_msg_ready    = 1'b0;
        DEBUG_msg_ready = 1'b0;
        msg_take        = 1'b0;
        mdl_errs        = 0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Single PD message, valid header.
        m = mk_msg(8'h01, 8'h82, 8'h00, 8'h00);
        auth_msg_in  = m;
        PD_msg_ready = 1'b1;
        tick();
        chk("t1_pd_ack", PD_ready, 1'b1);
        chk("t1_dbg_ack", DEBUG_ready, 1'b0);
        chk("t1_valid_early", msg_valid, 1'b0);
        PD_msg_ready = 1'b0;
        tick();
        chk("t1_ack_drop", PD_ready, 1'b0);
        chk("t1_valid", msg_valid, 1'b1);
        chk("t1_src", msg_src, 1'b0);
        chk("t1_type", msg_type, 8'h82);
        chk("t1_param1", msg_param1, 8'h00);
        chk("t1_data", msg_data, m);
        msg_take = 1'b1;
        tick();
        msg_take = 1'b0;
        chk("t1_popped", msg_valid, 1'b0);

        // Header table.
        last_code = 2'b00;
        for (int i = 0; i < 12; i++) begin
            m = mk_msg(tab[i].ver, tab[i].typ, tab[i].p1, tab[i].p2);
            auth_msg_in     = m;
            PD_msg_ready    = !tab[i].src;
            DEBUG_msg_ready = tab[i].src;
            tick();
            chk("tab_ack", tab[i].src ? DEBUG_ready : PD_ready, 1'b1);
            chk("tab_other_ack", tab[i].src ? PD_ready : DEBUG_ready, 1'b0);
            PD_msg_ready    = 1'b0;
            DEBUG_msg_ready = 1'b0;
            tick();
            chk("tab_err_valid", err_valid, tab[i].exp_err);
            chk("tab_msg_valid", msg_valid, !tab[i].exp_err);
            if (tab[i].exp_err) begin
                chk("tab_err_code", err_code, tab[i].exp_code);
                last_code = tab[i].exp_code;
                mdl_errs++;
                tick();
            end else begin
                chk("tab_err_code_held", err_code, last_code);
                chk("tab_src", msg_src, tab[i].src);
                chk("tab_type", msg_type, tab[i].typ);
                chk("tab_param1", msg_param1, tab[i].p1);
                chk("tab_param2", msg_param2, tab[i].p2);
                chk("tab_data", msg_data, m);
                msg_take = 1'b1;
                tick();
                msg_take = 1'b0;
                chk("tab_drained", msg_valid, 1'b0);
            end
            chk("tab_err_pulse_end", err_valid, 1'b0);
        end
`ifdef AUTH_RX_ERR_COUNT_EN
        chk("tab_err_count", err_count, 8'(mdl_errs));
`endif

        // Both sources held from reset: grants alternate, starting with PD.
        reset           = 1'b1;
        auth_msg_in     = mk_msg(8'h01, 8'h83, 8'h01, 8'h02);
        PD_msg_ready    = 1'b1;
        DEBUG_msg_ready = 1'b1;
        msg_take        = 1'b1;
        repeat (2) tick();
        reset    = 1'b0;
        mdl_errs = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (PD_ready && DEBUG_ready) chk("t2_dual_ack", 1'b1, 1'b0);
            if (PD_ready) ack_q.push_back(1'b0);
            if (DEBUG_ready) ack_q.push_back(1'b1);
            if (msg_valid) pop_q.push_back(msg_src);
        end
        PD_msg_ready    = 1'b0;
        DEBUG_msg_ready = 1'b0;
        chk("t2_ack_count", ack_q.size(), 6);
        chk("t2_pop_count", pop_q.size(), 6);
        for (int i = 0; i < ack_q.size(); i++) begin
            chk("t2_grant_order", ack_q[i], i[0]);
            if (i < pop_q.size()) chk("t2_queue_order", pop_q[i], ack_q[i]);
        end
        tick();
        chk("t2_drained", msg_valid, 1'b0);
        msg_take = 1'b0;

        // Back-pressure: third message waits in HOLD, no acks meanwhile.
        m1 = mk_msg(8'h01, 8'h81, 8'h41, 8'h00);
        m2 = mk_msg(8'h01, 8'h82, 8'h42, 8'h00);
        m3 = mk_msg(8'h01, 8'h03, 8'h43, 8'h00);
        m4 = mk_msg(8'h01, 8'h7F, 8'h44, 8'h00);
        send_msg(1'b0, m1, "t4_m1");
        send_msg(1'b0, m2, "t4_m2");
        send_msg(1'b0, m3, "t4_m3");
        chk("t4_full_head", msg_data, m1);
        auth_msg_in     = m4;
        DEBUG_msg_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_ack_in_hold", DEBUG_ready | PD_ready, 1'b0);
        end
        DEBUG_msg_ready = 1'b0;
        msg_take = 1'b1;
        tick();
        msg_take = 1'b0;
        chk("t4_head_m2", msg_data, m2);
        chk("t4_valid", msg_valid, 1'b1);
        msg_take = 1'b1;
        tick();
        chk("t4_head_m3", msg_data, m3);
        tick();
        chk("t4_empty", msg_valid, 1'b0);
        chk("t4_abandoned_no_ack", DEBUG_ready, 1'b0);
        msg_take = 1'b0;

        // Full queue with pop and push on the same edge.
        m1 = mk_msg(8'h01, 8'h81, 8'h61, 8'h00);
        m2 = mk_msg(8'h01, 8'h82, 8'h62, 8'h00);
        m3 = mk_msg(8'h01, 8'h83, 8'h63, 8'h00);
        m4 = mk_msg(8'h01, 8'h02, 8'h64, 8'h00);
        send_msg(1'b0, m1, "t6_m1");
        send_msg(1'b0, m2, "t6_m2");
        auth_msg_in  = m3;
        PD_msg_ready = 1'b1;
        tick();
        chk("t6_m3_ack", PD_ready, 1'b1);
        PD_msg_ready = 1'b0;
        msg_take     = 1'b1;
        tick();
        msg_take = 1'b0;
        chk("t6_head_m2", msg_data, m2);
        auth_msg_in     = m4;
        DEBUG_msg_ready = 1'b1;
        tick();
        chk("t6_no_hold_ack", DEBUG_ready, 1'b1);
        DEBUG_msg_ready = 1'b0;
        tick();
        chk("t6_head_still_m2", msg_data, m2);
        msg_take = 1'b1;
        tick();
        chk("t6_head_m3", msg_data, m3);
        tick();
        chk("t6_head_m4", msg_data, m4);
        chk("t6_src_m4", msg_src, 1'b1);
        tick();
        chk("t6_empty", msg_valid, 1'b0);
        msg_take = 1'b0;

        // Reset while a message sits in CHECK and the queue holds one entry.
        m1 = mk_msg(8'h01, 8'h81, 8'h71, 8'h00);
        m2 = mk_msg(8'h01, 8'h82, 8'h72, 8'h00);
        send_msg(1'b0, m1, "t5_m1");
        auth_msg_in  = m2;
        PD_msg_ready = 1'b1;
        tick();
        chk("t5_ack", PD_ready, 1'b1);
        PD_msg_ready = 1'b0;
        reset        = 1'b1;
        tick();
        chk_idle_outputs("t5_reset");
        reset    = 1'b0;
        mdl_errs = 0;
        repeat (2) tick();
        chk("t5_no_reack", PD_ready, 1'b0);
        chk("t5_queue_empty", msg_valid, 1'b0);

        // Randomized traffic against the transaction-level model.
        begin
            logic               mdl_last, pd_pend, dbg_pend, drv_pd, drv_dbg, pred;
            logic               prev_ack, ack_now, err_due, finished;
            logic [1:0]         due_code, code;
            logic [MSG_LEN-1:0] pd_msg, dbg_msg, drv_msg;
            ent_t               e;
            mdl_last = 1'b1;
            pd_pend  = 1'b0;
            dbg_pend = 1'b0;
            drv_pd   = 1'b0;
            drv_dbg  = 1'b0;
            pred     = 1'b0;
            prev_ack = 1'b0;
            err_due  = 1'b0;
            due_code = 2'b00;
            finished = 1'b0;
            pd_msg   = '0;
            dbg_msg  = '0;
            drv_msg  = '0;
            exp_q.delete();
            for (int cyc = 0; cyc < 1200 && !finished; cyc++) begin
                tick();
                chk("rnd_err_valid", err_valid, err_due);
                if (err_due) chk("rnd_err_code", err_code, due_code);
                err_due = 1'b0;
                ack_now = PD_ready | DEBUG_ready;
                if (ack_now) begin
                    chk("rnd_ack_single", PD_ready & DEBUG_ready, 1'b0);
                    chk("rnd_ack_gap", prev_ack, 1'b0);
                    chk("rnd_ack_winner", DEBUG_ready, pred);
                    chk("rnd_ack_requested", pred ? drv_dbg : drv_pd, 1'b1);
                    mdl_last = pred;
                    code = ref_err(drv_msg[MSG_LEN-1 -: 8], drv_msg[MSG_LEN-9 -: 8]);
                    if (code != 2'b00) begin
                        err_due  = 1'b1;
                        due_code = code;
                        mdl_errs++;
                    end else begin
                        exp_q.push_back('{pred, drv_msg});
                    end
                    if (pred) dbg_pend = 1'b0;
                    else pd_pend = 1'b0;
                end
                prev_ack = ack_now;

                msg_take = (cyc < 400) ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (msg_valid && msg_take) begin
                    chk("rnd_pop_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rnd_pop_src", msg_src, e.src);
                        chk("rnd_pop_data", msg_data, e.data);
                    end
                end

                if (cyc < 400) begin
                    if (!pd_pend && $urandom_range(0, 2) == 0) begin
                        pd_pend = 1'b1;
                        pd_msg  = rand_msg();
                    end
                    if (!dbg_pend && $urandom_range(0, 2) == 0) begin
                        dbg_pend = 1'b1;
                        dbg_msg  = rand_msg();
                    end
                end
                pred    = (pd_pend && dbg_pend) ? !mdl_last : dbg_pend;
                drv_msg = pred ? dbg_msg : pd_msg;
                drv_pd  = pd_pend;
                drv_dbg = dbg_pend;
                PD_msg_ready    = pd_pend;
                DEBUG_msg_ready = dbg_pend;
                auth_msg_in     = drv_msg;
                if (cyc >= 400 && !pd_pend && !dbg_pend && exp_q.size() == 0
                    && !msg_valid && !err_due) finished = 1'b1;
            end
            chk("rnd_finished", finished, 1'b1);
            chk("rnd_queue_drained", exp_q.size(), 0);
        end
`ifdef AUTH_RX_ERR_COUNT_EN
        chk("rnd_err_count", err_count, (mdl_errs > 255) ? 8'hFF : 8'(mdl_errs));
`endif
        msg_take = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
